// File: rtl/i2c_iobuf_master.sv
// Byte-level I2C master for open-drain IOBUF pads. It runs one START, STOP, WRITE or READ command
// at a time and lets the slave stretch the clock while SCL is released.
module i2c_iobuf_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_in,
  output logic       scl_t,
  output logic       sda_t,
  input  logic       scl_i,
  input  logic       sda_i
);
  localparam logic [11:0] CNT_LAST = 12'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, STOP, DATA} state_e;

  state_e      state_q;
  logic [1:0]  phase_q;
  logic [3:0]  bit_q;
  logic [11:0] cnt_q;
  logic        fin_q, is_rd_q, is_wr_q, rack_q, ack_q;
  logic [7:0]  wdat_q, shift_q, rd_data_q;
  logic        cmd_ready_q, rsp_valid_q, ack_in_q, scl_t_q, sda_t_q;
  logic        scl_m_q, scl_s_q, sda_m_q, sda_s_q;

  logic        scl_d, sda_d, data_bit, phase_end;
  logic [2:0]  bidx;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rd_data   = rd_data_q;
  assign ack_in    = ack_in_q;
  assign scl_t     = scl_t_q;
  assign sda_t     = sda_t_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
    end else begin
      scl_m_q <= scl_i;
      scl_s_q <= scl_m_q;
      sda_m_q <= sda_i;
      sda_s_q <= sda_m_q;
    end
  end

  // Pin levels for the current phase. They are registered on the next edge, so the pads trail the
  // phase by one cycle. In IDLE the pins keep their last level.
  always_comb begin
    bidx     = 3'(bit_q - 4'd1);
    data_bit = 1'b1;
    if (bit_q == 4'd0)  data_bit = is_rd_q ? rack_q : 1'b1;
    else if (!is_rd_q)  data_bit = wdat_q[bidx];
    scl_d = scl_t_q;
    sda_d = sda_t_q;
    case (state_q)
      START: begin
        scl_d = (phase_q != 2'd3);
        sda_d = (phase_q < 2'd2);
      end
      STOP: begin
        scl_d = (phase_q != 2'd0);
        sda_d = (phase_q == 2'd3);
      end
      DATA: begin
        scl_d = phase_q[1];
        sda_d = data_bit;
      end
      default: ;
    endcase
    // A released-SCL phase cannot end until the synchronized line is actually high.
    phase_end = (cnt_q == CNT_LAST) && (scl_s_q || !scl_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      is_rd_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      rack_q      <= 1'b1;
      ack_q       <= 1'b1;
      wdat_q      <= '0;
      shift_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
      ack_in_q    <= 1'b1;
      scl_t_q     <= 1'b1;
      sda_t_q     <= 1'b1;
    end else begin
      scl_t_q     <= scl_d;
      sda_t_q     <= sda_d;
      rsp_valid_q <= 1'b0;
      if (fin_q) begin
        fin_q       <= 1'b0;
        rsp_valid_q <= 1'b1;
        cmd_ready_q <= 1'b1;
        if (is_rd_q) rd_data_q <= shift_q;
        if (is_wr_q) ack_in_q  <= ack_q;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            wdat_q      <= wr_data;
            rack_q      <= rd_ack;
            is_rd_q     <= (cmd == 3'b011);
            is_wr_q     <= (cmd == 3'b010);
            cnt_q       <= '0;
            phase_q     <= '0;
            bit_q       <= 4'd8;
            case (cmd)
              3'b000:         state_q <= START;
              3'b001:         state_q <= STOP;
              3'b010, 3'b011: state_q <= DATA;
              default:        fin_q   <= 1'b1;
            endcase
          end
        end
        default: begin
          if (phase_end) begin
            cnt_q <= '0;
            if (state_q == DATA && phase_q == 2'd2) begin
              if (bit_q == 4'd0) ack_q   <= sda_s_q;
              else               shift_q <= {shift_q[6:0], sda_s_q};
            end
            if (phase_q == 2'd3) begin
              phase_q <= '0;
              if (state_q == DATA && bit_q != 4'd0) begin
                bit_q <= bit_q - 4'd1;
              end else begin
                state_q <= IDLE;
                fin_q   <= 1'b1;
              end
            end else begin
              phase_q <= phase_q + 2'd1;
            end
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_iobuf_master.sv
// Randomized bench for i2c_iobuf_master: an open-drain bus with a behavioural slave, plus a
// bit-level bus monitor checked against the byte and ACK values each command should produce.
module tb_i2c_iobuf_master;
  localparam int DIV = 4;
  localparam int LAT_PH = 1 + 4 * DIV;
  localparam int LAT_BYTE = 1 + 36 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'b000;
  logic [7:0] wr_data = 8'h00;
  logic       rd_ack = 1'b1;
  logic       cmd_ready, rsp_valid, ack_in, scl_t, sda_t;
  logic [7:0] rd_data;
  logic       scl_line, sda_line;

  logic       slv_sda_low = 1'b0;
  logic       slv_scl_low = 1'b0;
  int         slv_mode = 0;
  logic [7:0] slv_byte = 8'h00;
  int         slv_base = 0;

  int         rises = 0;
  int         nstart = 0;
  int         nstop = 0;
  logic       bits_q[$];
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;

  int         checks = 0;
  int         failures = 0;
  int         lat_g = 0;
  logic [7:0] exp_rd = 8'h00;
  logic       exp_ack = 1'b1;

  always #5 clk = ~clk;

  assign scl_line = !(!scl_t || slv_scl_low);
  assign sda_line = !(!sda_t || slv_sda_low);

  i2c_iobuf_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wr_data(wr_data), .rd_ack(rd_ack), .rsp_valid(rsp_valid), .rd_data(rd_data),
    .ack_in(ack_in), .scl_t(scl_t), .sda_t(sda_t), .scl_i(scl_line), .sda_i(sda_line)
  );

  // Bus monitor plus slave: records SDA on every SCL rise, flags START/STOP conditions and
  // changes the slave's SDA only while SCL is low.
  always @(negedge clk) begin : slave
    int r;
    if (scl_line && !scl_prev) begin
      rises++;
      bits_q.push_back(sda_line);
    end
    if (scl_line && scl_prev && sda_prev && !sda_line) nstart++;
    if (scl_line && scl_prev && !sda_prev && sda_line) nstop++;
    scl_prev = scl_line;
    sda_prev = sda_line;
    if (!scl_line) begin
      r = rises - slv_base;
      slv_sda_low = 1'b0;
      if (slv_mode == 1 && r == 8) slv_sda_low = 1'b1;
      if (slv_mode == 2 && r < 8) slv_sda_low = !slv_byte[7 - r];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] wd, input logic ra);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd = c;
    wr_data = wd;
    rd_ack = ra;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts edges from acceptance to rsp_valid; optionally pokes a STOP request while busy.
  task automatic wait_rsp(input int poke_at);
    lat_g = 0;
    do begin
      @(posedge clk);
      lat_g++;
      #1;
      cmd_valid = 1'b0;
      if (lat_g == poke_at) begin
        cmd = 3'b001;
        cmd_valid = 1'b1;
      end
    end while (!rsp_valid && lat_g < 3000);
    cmd_valid = 1'b0;
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic stretch(input int n);
    int k = 0;
    while (!((rises - slv_base) == 3 && !scl_t) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    slv_scl_low = 1'b1;
    k = 0;
    while (!scl_t && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (n) @(posedge clk);
    #1 slv_scl_low = 1'b0;
  endtask

  task automatic do_ctl(input logic [2:0] c, input int poke_at);
    int s0 = nstart;
    int p0 = nstop;
    issue(c, 8'h00, 1'b1);
    wait_rsp(poke_at);
    chk(c == 3'b000 ? "start_latency" : "stop_latency", lat_g, LAT_PH);
    if (c == 3'b000) begin
      chk("start_cond_seen", nstart - s0, 1);
      chk("start_pins", {scl_t, sda_t}, 2'b00);
    end else begin
      chk("stop_cond_seen", nstop - p0, 1);
      chk("stop_pins", {scl_t, sda_t}, 2'b11);
    end
  endtask

  task automatic do_xfer(input logic rd, input logic [7:0] b, input logic sack, input logic ra,
                         input int nstr);
    int qb;
    logic [7:0] got;
    slv_base = rises;
    qb = bits_q.size();
    slv_byte = b;
    slv_mode = rd ? 2 : (sack ? 1 : 0);
    issue(rd ? 3'b011 : 3'b010, b, ra);
    if (nstr > 0) begin
      fork
        stretch(nstr);
        wait_rsp(0);
      join
    end else begin
      wait_rsp(0);
    end
    chk(rd ? "read_latency" : "write_latency", lat_g, LAT_BYTE + nstr);
    chk("bus_bit_count", bits_q.size() - qb, 9);
    got = 8'h00;
    for (int i = 0; i < 8 && qb + i < bits_q.size(); i++) got = {got[6:0], bits_q[qb + i]};
    chk(rd ? "read_byte_on_bus" : "write_byte_on_bus", got, b);
    if (qb + 8 < bits_q.size())
      chk("ack_bit_on_bus", bits_q[qb + 8], rd ? ra : !sack);
    if (rd) begin
      exp_rd = b;
      chk("sda_t_ack_bit", sda_t, ra);
    end else begin
      exp_ack = !sack;
    end
    chk("rd_data", rd_data, exp_rd);
    chk("ack_in", ack_in, exp_ack);
    slv_mode = 0;
  endtask

  initial begin
    logic       rd, sa, ra, ps, pd;
    logic [7:0] b;
    int         pulses, p0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_scl_t", scl_t, 1);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_ack_in", ack_in, 1);
    repeat (4) @(posedge clk);

    do_ctl(3'b000, 0);
    do_xfer(1'b0, 8'hA5, 1'b1, 1'b1, 0);
    do_xfer(1'b1, 8'h3C, 1'b0, 1'b1, 0);
    do_xfer(1'b0, 8'($urandom), 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      rd = 1'($urandom_range(0, 1));
      sa = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      do_xfer(rd, b, sa, ra, 0);
    end
    do_ctl(3'b001, 0);

    @(negedge clk);
    ps = scl_t;
    pd = sda_t;
    issue(3'b110, 8'h00, 1'b1);
    wait_rsp(0);
    chk("reserved_latency", lat_g, 1);
    chk("reserved_pins", {scl_t, sda_t}, {ps, pd});

    do_ctl(3'b000, 0);
    do_xfer(1'b0, 8'($urandom), 1'b1, 1'b1, 50);
    do_ctl(3'b001, 0);

    p0 = nstop;
    do_ctl(3'b000, 5);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (rsp_valid) pulses++;
    end
    chk("busy_request_ignored", pulses, 0);
    chk("busy_no_stop", nstop - p0, 0);
    chk("busy_ready", cmd_ready, 1);

    slv_base = rises;
    slv_mode = 1;
    issue(3'b010, 8'h5A, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_scl_t", scl_t, 1);
    chk("midrst_sda_t", sda_t, 1);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    slv_mode = 0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 if (rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", pulses, 0);
    chk("midrst_idle_pins", {scl_t, sda_t}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
